// File: rtl/pipe_seg_pkg.sv
// Shared defaults and payload field map for every pipe_seg_hs stage instance.
package pipe_seg_pkg;

  localparam int PAYLOAD_W_DEF = 224;
  localparam int OPND_N_DEF    = 2;
  localparam int OPND_W_DEF    = 32;

  // Payload field layout, common to ID/EX, EX/MEM, ... instances
  localparam int PL_EXC_LSB    = 0;
  localparam int PL_EXC_W      = 8;
  localparam int PL_PC_LSB     = 8;
  localparam int PL_PC_W       = 32;
  localparam int PL_INST_LSB   = 40;
  localparam int PL_INST_W     = 32;
  localparam int PL_REGWEN_BIT = 72;
  localparam int PL_WREG_LSB   = 73;
  localparam int PL_WREG_W     = 5;
  localparam int PL_CP0_LSB    = 78;
  localparam int PL_CP0_W      = 16;
  localparam int PL_HILO_LSB   = 94;
  localparam int PL_HILO_W     = 4;

  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/pipe_seg_hs_skid_buf.sv
// One-entry skid buffer behind the head register; built only when PIPE_SEG_SKID_EN is defined.
`ifdef PIPE_SEG_SKID_EN
module seg_skid_buf
  import pipe_seg_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int OPND_N    = OPND_N_DEF,
  parameter int OPND_W    = OPND_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     load,
  input  logic                     pop,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  input  logic [OPND_N*OPND_W-1:0] in_opnd,
  output logic                     valid,
  output logic [PAYLOAD_W-1:0]     payload,
  output logic [OPND_N*OPND_W-1:0] opnd
);

  // Skid entry: filled while the head is held, drained when the head frees up
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid   <= 1'b0;
      payload <= '0;
      opnd    <= '0;
    end else if (flush) begin
      valid   <= 1'b0;
      payload <= '0;
      opnd    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= in_payload;
      opnd    <= in_opnd;
    end else if (pop) begin
      valid   <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/pipe_seg_hs.sv
// Generic valid/ready pipeline segment with patchable operand lanes and flush.
// Optional one-entry skid buffer enabled by defining PIPE_SEG_SKID_EN.
module pipe_seg_hs
  import pipe_seg_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int OPND_N    = OPND_N_DEF,
  parameter int OPND_W    = OPND_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  input  logic [OPND_N*OPND_W-1:0] in_opnd,
  input  logic [OPND_N-1:0]        patch_en,
  input  logic [OPND_N*OPND_W-1:0] patch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_W-1:0]     out_payload,
  output logic [OPND_N*OPND_W-1:0] out_opnd,
  output logic [OPND_N-1:0]        out_patched
);

  logic                     hold;
  logic                     xfer_out;
  logic                     accept;
  logic                     base_ready;
  logic                     load_head;
  logic [PAYLOAD_W-1:0]     load_payload;
  logic [OPND_N*OPND_W-1:0] load_opnd;

  assign hold     = out_valid & ~out_ready;
  assign xfer_out = out_valid & out_ready;
  assign in_ready = base_ready & ~flush;
  assign accept   = in_valid & in_ready;

`ifdef PIPE_SEG_SKID_EN
  logic                     skid_valid;
  logic [PAYLOAD_W-1:0]     skid_payload;
  logic [OPND_N*OPND_W-1:0] skid_opnd;

  assign base_ready = ~skid_valid;

  seg_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W),
    .OPND_N    (OPND_N),
    .OPND_W    (OPND_W)
  ) u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .load       (accept & hold),
    .pop        (skid_valid & ~hold),
    .in_payload (in_payload),
    .in_opnd    (in_opnd),
    .valid      (skid_valid),
    .payload    (skid_payload),
    .opnd       (skid_opnd)
  );

  // Head source: the older skid entry always wins over a fresh input
  always_comb begin
    load_head    = 1'b0;
    load_payload = in_payload;
    load_opnd    = in_opnd;
    if (!hold && skid_valid) begin
      load_head    = 1'b1;
      load_payload = skid_payload;
      load_opnd    = skid_opnd;
    end else if (!hold && accept) begin
      load_head    = 1'b1;
    end else begin
      load_head    = 1'b0;
    end
  end
`else
  assign base_ready = ~out_valid | out_ready;

  // Without a skid, an accepted entry always lands directly in the head
  always_comb begin
    load_head    = 1'b0;
    load_payload = in_payload;
    load_opnd    = in_opnd;
    if (accept) begin
      load_head = 1'b1;
    end else begin
      load_head = 1'b0;
    end
  end
`endif

  // Head register: flush, then load, then drain, then in-place lane patching while held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_opnd    <= '0;
      out_patched <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_opnd    <= '0;
      out_patched <= '0;
    end else if (load_head) begin
      out_valid   <= 1'b1;
      out_payload <= load_payload;
      out_opnd    <= load_opnd;
      out_patched <= '0;
    end else if (xfer_out) begin
      out_valid   <= 1'b0;
    end else if (hold) begin
      for (int i = 0; i < OPND_N; i++) begin
        if (patch_en[i]) begin
          out_opnd[lane_lsb(i, OPND_W) +: OPND_W] <= patch_data[lane_lsb(i, OPND_W) +: OPND_W];
          out_patched[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_seg_hs.sv
// Self-checking bench for pipe_seg_hs: queue-level reference model plus directed literal checks.
module tb_pipe_seg_hs;

  localparam int PW = 224;
  localparam int ON = 2;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [63:0]   in_opnd;
  logic [1:0]    patch_en;
  logic [63:0]   patch_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [63:0]   out_opnd;
  logic [1:0]    out_patched;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  pipe_seg_hs #(.PAYLOAD_W(PW), .OPND_N(ON), .OPND_W(OW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_opnd     (in_opnd),
    .patch_en    (patch_en),
    .patch_data  (patch_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_opnd    (out_opnd),
    .out_patched (out_patched)
  );

  typedef struct {
    logic [PW-1:0] payload;
    logic [63:0]   opnd;
    logic [1:0]    patched;
  } ent_t;

  // Model: q[0] is the head entry, q[1] (skid build only) the waiting entry
  ent_t q[$];

  function automatic logic model_ready();
`ifdef PIPE_SEG_SKID_EN
    return (q.size() < 2) && !flush;
`else
    return ((q.size() == 0) || out_ready) && !flush;
`endif
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn || flush) begin
        q.delete();
      end else begin
        logic acc;
        logic pop;
        acc = in_valid && model_ready();
        pop = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready) begin
          ent_t h;
          h = q[0];
          for (int i = 0; i < ON; i++) begin
            if (patch_en[i]) begin
              h.opnd[i*OW +: OW] = patch_data[i*OW +: OW];
              h.patched[i] = 1'b1;
            end
          end
          q[0] = h;
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
          ent_t e;
          e.payload = in_payload;
          e.opnd    = in_opnd;
          e.patched = 2'b00;
          q.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        check("in_ready", {255'd0, in_ready}, {255'd0, model_ready()});
        check("out_valid", {255'd0, out_valid}, {255'd0, (q.size() > 0)});
        if (q.size() > 0) begin
          check("out_payload", {32'd0, out_payload}, {32'd0, q[0].payload});
          check("out_opnd", {192'd0, out_opnd}, {192'd0, q[0].opnd});
          check("out_patched", {254'd0, out_patched}, {254'd0, q[0].patched});
        end
      end
    end
  end

  task automatic set(input logic iv, input logic [PW-1:0] pl, input logic [63:0] op,
                     input logic ordy, input logic [1:0] pe, input logic [63:0] pd,
                     input logic fl);
    in_valid   = iv;
    in_payload = pl;
    in_opnd    = op;
    out_ready  = ordy;
    patch_en   = pe;
    patch_data = pd;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    set(1'b0, '0, 64'd0, 1'b1, 2'b00, 64'd0, 1'b0);
    #3;
    check("rst_valid", {255'd0, out_valid}, 256'd0);
    check("rst_payload", {32'd0, out_payload}, 256'd0);
    check("rst_opnd", {192'd0, out_opnd}, 256'd0);
    check("rst_patched", {254'd0, out_patched}, 256'd0);
    #9;
    resetn = 1'b1;
    tick();

    // Stream 1,2,3 with no gaps
    for (int k = 1; k <= 3; k++) begin
      set(1'b1, PW'(k), {32'h0, 32'(k)}, 1'b1, 2'b00, 64'd0, 1'b0);
      tick();
      check("stream_valid", {255'd0, out_valid}, 256'd1);
      check("stream_payload", {32'd0, out_payload}, 256'(k));
    end
    set(1'b0, '0, 64'd0, 1'b1, 2'b00, 64'd0, 1'b0);
    tick();
    check("stream_drain", {255'd0, out_valid}, 256'd0);

    // Hold and patch lane 0
    set(1'b1, PW'(32'h20), {32'h22, 32'h11}, 1'b0, 2'b00, 64'd0, 1'b0);
    tick();
    set(1'b0, '0, 64'd0, 1'b0, 2'b01, {32'hBB, 32'hAA}, 1'b0);
    tick();
    check("patch_opnd", {192'd0, out_opnd}, {192'd0, 32'h22, 32'hAA});
    check("patch_flags", {254'd0, out_patched}, 256'd1);
    check("patch_payload", {32'd0, out_payload}, 256'h20);
    set(1'b1, PW'(32'h21), {32'h44, 32'h33}, 1'b1, 2'b00, 64'd0, 1'b0);
    tick();
    check("next_unpatched", {254'd0, out_patched}, 256'd0);
    check("next_payload", {32'd0, out_payload}, 256'h21);

    // Patch while head transfers out is ignored
    set(1'b1, PW'(32'h22), {32'h66, 32'h55}, 1'b1, 2'b11, {32'hEE, 32'hDD}, 1'b0);
    tick();
    check("xfer_patch_flags", {254'd0, out_patched}, 256'd0);
    check("xfer_patch_opnd", {192'd0, out_opnd}, {192'd0, 32'h66, 32'h55});

    // Flush beats accept and patch
    set(1'b1, PW'(32'h99), {32'h98, 32'h97}, 1'b0, 2'b11, {32'hEE, 32'hDD}, 1'b1);
    #1;
    check("flush_in_ready", {255'd0, in_ready}, 256'd0);
    tick();
    check("flush_valid", {255'd0, out_valid}, 256'd0);
    check("flush_payload", {32'd0, out_payload}, 256'd0);
    check("flush_opnd", {192'd0, out_opnd}, 256'd0);
    check("flush_patched", {254'd0, out_patched}, 256'd0);
    set(1'b0, '0, 64'd0, 1'b0, 2'b00, 64'd0, 1'b0);
    tick();
    check("flush_no_accept", {255'd0, out_valid}, 256'd0);

    // Back-to-back entries against a stalled consumer
    set(1'b1, PW'(32'hA), {32'h0, 32'hA}, 1'b0, 2'b00, 64'd0, 1'b0);
    tick();
    check("a_head", {32'd0, out_payload}, 256'hA);
    set(1'b1, PW'(32'hB), {32'h0, 32'hB}, 1'b0, 2'b00, 64'd0, 1'b0);
    #1;
`ifdef PIPE_SEG_SKID_EN
    check("b_ready", {255'd0, in_ready}, 256'd1);
`else
    check("b_ready", {255'd0, in_ready}, 256'd0);
`endif
    tick();
    set(1'b0, '0, 64'd0, 1'b0, 2'b00, 64'd0, 1'b0);
    #1;
    check("held_ready", {255'd0, in_ready}, 256'd0);
    check("held_head", {32'd0, out_payload}, 256'hA);
    set(1'b0, '0, 64'd0, 1'b1, 2'b00, 64'd0, 1'b0);
    #1;
`ifdef PIPE_SEG_SKID_EN
    check("drain_ready", {255'd0, in_ready}, 256'd0);
`else
    check("drain_ready", {255'd0, in_ready}, 256'd1);
`endif
    tick();
`ifdef PIPE_SEG_SKID_EN
    check("skid_to_head", {32'd0, out_payload}, 256'hB);
    check("skid_valid", {255'd0, out_valid}, 256'd1);
`else
    check("skid_valid", {255'd0, out_valid}, 256'd0);
`endif
    #1;
    check("ready_back", {255'd0, in_ready}, 256'd1);
    tick();

    // Asynchronous reset mid-hold
    set(1'b1, PW'(32'h66), {32'h78, 32'h77}, 1'b0, 2'b00, 64'd0, 1'b0);
    tick();
    set(1'b0, '0, 64'd0, 1'b0, 2'b00, 64'd0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", {255'd0, out_valid}, 256'd0);
    check("async_rst_opnd", {192'd0, out_opnd}, 256'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_valid", {255'd0, out_valid}, 256'd0);

    // Mixed traffic checked only by the model
    for (int k = 0; k < 200; k++) begin
      set(1'($urandom_range(0, 3) != 0), PW'({$urandom, $urandom}), {$urandom, $urandom},
          1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), {$urandom, $urandom},
          1'($urandom_range(0, 15) == 0));
      tick();
    end

    set(1'b0, '0, 64'd0, 1'b1, 2'b00, 64'd0, 1'b0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
